// File: rtl/decoder_seq.sv
// Registered one-hot decoder with a valid/ready command port, range checking
// and a scan mode that walks the one-hot across the outputs with a dwell time.
module decoder_seq #(
    parameter int N_SEL      = 3,
    parameter int N_OUT      = 8,
    parameter int SCAN_DWELL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_SEL-1:0] in_sel,
    input  logic [1:0]       in_mode,
    input  logic             stop,
    input  logic             out_en,
    output logic [N_OUT-1:0] z,
    output logic             z_valid,
    output logic             busy,
    output logic             err_range,
    output logic             done
);

    localparam int              CW      = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
    localparam logic [N_SEL:0]   OUT_LIM = (N_SEL+1)'(N_OUT);
    localparam logic [N_SEL-1:0] LAST    = N_SEL'(N_OUT - 1);
    localparam logic [CW-1:0]    DW_LOAD = CW'(SCAN_DWELL - 1);

    typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
    typedef enum logic [1:0] {M_DECODE, M_SCAN_ONCE, M_SCAN_LOOP, M_CLEAR} mode_t;

    state_t             state, state_n;
    logic [N_OUT-1:0]   z_reg, z_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [N_SEL-1:0]   idx, idx_n;
    logic               loop, loop_n;
    logic               err_n, done_n;
    logic               accept;
    mode_t              mode;

    function automatic logic [N_OUT-1:0] onehot(input logic [N_SEL-1:0] s);
        return N_OUT'(1) << s;
    endfunction

    assign mode     = mode_t'(in_mode);
    assign in_ready = rst_n && (state != SCAN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == SCAN);
    assign z_valid  = |z_reg;
    assign z        = z_reg & {N_OUT{out_en}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            z_reg     <= '0;
            cnt       <= '0;
            idx       <= '0;
            loop      <= 1'b0;
            err_range <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            z_reg     <= z_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            loop      <= loop_n;
            err_range <= err_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        z_n     = z_reg;
        cnt_n   = cnt;
        idx_n   = idx;
        loop_n  = loop;
        err_n   = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    if (mode == M_CLEAR) begin
                        z_n     = '0;
                        state_n = IDLE;
                    end else if ({1'b0, in_sel} >= OUT_LIM) begin
                        err_n   = 1'b1;
                        z_n     = '0;
                        state_n = IDLE;
                    end else begin
                        z_n   = onehot(in_sel);
                        idx_n = in_sel;
                        if (mode == M_DECODE) begin
                            state_n = HOLD;
                        end else begin
                            state_n = SCAN;
                            cnt_n   = DW_LOAD;
                            loop_n  = (mode == M_SCAN_LOOP);
                        end
                    end
                end
            end
            SCAN: begin
                if (stop) begin
                    z_n     = '0;
                    state_n = IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (idx == LAST) begin
                    // Wrap by explicit compare so non-power-of-two N_OUT never visits unused indices
                    if (loop) begin
                        idx_n = '0;
                        z_n   = onehot('0);
                        cnt_n = DW_LOAD;
                    end else begin
                        z_n     = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    idx_n = idx + N_SEL'(1);
                    z_n   = onehot(idx + N_SEL'(1));
                    cnt_n = DW_LOAD;
                end
            end
            default: begin
                z_n     = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: two instances (8 outputs/dwell 2, 6 outputs/dwell 1)
// share stimulus and are compared each cycle against an arithmetic scan model.
module tb_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_sel;
    logic [1:0] in_mode;
    logic       stop;
    logic       out_en;

    logic [7:0] z_a;
    logic       zv_a, busy_a, err_a, done_a, rdy_a;
    logic [5:0] z_b;
    logic       zv_b, busy_b, err_b, done_b, rdy_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decoder_seq #(.N_SEL(3), .N_OUT(8), .SCAN_DWELL(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_sel(in_sel), .in_mode(in_mode), .stop(stop), .out_en(out_en),
        .z(z_a), .z_valid(zv_a), .busy(busy_a), .err_range(err_a), .done(done_a)
    );

    decoder_seq #(.N_SEL(3), .N_OUT(6), .SCAN_DWELL(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_sel(in_sel), .in_mode(in_mode), .stop(stop), .out_en(out_en),
        .z(z_b), .z_valid(zv_b), .busy(busy_b), .err_range(err_b), .done(done_b)
    );

    // Reference: a scan is "start index + elapsed edges / dwell", ending or wrapping at N_OUT.
    int NO [2] = '{8, 6};
    int DW [2] = '{2, 1};
    int m_z [2];
    int m_sel0 [2];
    int m_e [2];
    bit m_scan [2];
    bit m_loop [2];
    bit m_err [2];
    bit m_done [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_z[i] = 0; m_scan[i] = 0; m_loop[i] = 0;
            m_err[i] = 0; m_done[i] = 0; m_e[i] = 0; m_sel0[i] = 0;
        end
    endtask

    task automatic model_edge();
        int pos;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            m_err[i]  = 0;
            m_done[i] = 0;
            if (m_scan[i]) begin
                if (stop) begin
                    m_z[i] = 0;
                    m_scan[i] = 0;
                end else begin
                    m_e[i]++;
                    pos = m_sel0[i] + m_e[i] / DW[i];
                    if (!m_loop[i] && pos >= NO[i]) begin
                        m_z[i] = 0;
                        m_done[i] = 1;
                        m_scan[i] = 0;
                    end else begin
                        m_z[i] = 1 << (pos % NO[i]);
                    end
                end
            end else if (in_valid) begin
                if (in_mode == 2'b11) begin
                    m_z[i] = 0;
                end else if (int'(in_sel) >= NO[i]) begin
                    m_err[i] = 1;
                    m_z[i] = 0;
                end else begin
                    m_z[i] = 1 << in_sel;
                    if (in_mode != 2'b00) begin
                        m_scan[i] = 1;
                        m_loop[i] = (in_mode == 2'b10);
                        m_sel0[i] = int'(in_sel);
                        m_e[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_inst(input int i, input string p, input logic [7:0] z,
                              input logic zv, input logic bs, input logic er,
                              input logic dn, input logic rd);
        logic [7:0] ez;
        ez = out_en ? 8'(m_z[i]) : 8'h00;
        chk({p, ".z"},         z,         ez);
        chk({p, ".z_valid"},   {7'b0, zv}, {7'b0, m_z[i] != 0});
        chk({p, ".busy"},      {7'b0, bs}, {7'b0, m_scan[i]});
        chk({p, ".err_range"}, {7'b0, er}, {7'b0, m_err[i]});
        chk({p, ".done"},      {7'b0, dn}, {7'b0, m_done[i]});
        chk({p, ".in_ready"},  {7'b0, rd}, {7'b0, rst_n && !m_scan[i]});
    endtask

    task automatic check_all();
        check_inst(0, "a", z_a, zv_a, busy_a, err_a, done_a, rdy_a);
        check_inst(1, "b", {2'b00, z_b}, zv_b, busy_b, err_b, done_b, rdy_b);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic cmd(input logic [1:0] mode, input logic [2:0] sel);
        in_valid = 1'b1;
        in_mode  = mode;
        in_sel   = sel;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_mode = '0;
        stop = 1'b0; out_en = 1'b1;
        model_reset();
        #2 check_all();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back DECODE of every select; instance b flags 6 and 7
        in_valid = 1'b1;
        in_mode  = 2'b00;
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            tick();
        end
        in_valid = 1'b0;
        tick();

        // Out-of-range while holding, then recover
        cmd(2'b00, 3'd2);
        cmd(2'b00, 3'd6);
        cmd(2'b00, 3'd5);
        tick();

        // SCAN_ONCE from 5 with command pulses offered during the scan
        cmd(2'b01, 3'd5);
        for (int k = 0; k < 8; k++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_mode  = 2'b00;
            in_sel   = 3'($urandom_range(0, 5));
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();

        // SCAN_LOOP from 4, then stop with a simultaneous command
        cmd(2'b10, 3'd4);
        for (int k = 0; k < 10; k++) tick();
        stop = 1'b1; in_valid = 1'b1; in_mode = 2'b00; in_sel = 3'd1;
        tick();
        stop = 1'b0; in_valid = 1'b0;
        tick();

        // Output gate masks z only
        cmd(2'b00, 3'd3);
        out_en = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        out_en = 1'b1;
        tick();

        // Asynchronous reset in the middle of a running loop
        cmd(2'b10, 3'd0);
        for (int k = 0; k < 5; k++) tick();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        tick();
        rst_n = 1'b1;
        tick();

        // CLEAR from hold and an edge-case single-dwell SCAN_ONCE
        cmd(2'b00, 3'd1);
        cmd(2'b11, 3'd7);
        cmd(2'b01, 3'd5);
        for (int k = 0; k < 4; k++) tick();

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_mode  = 2'($urandom_range(0, 3));
            in_sel   = 3'($urandom_range(0, 7));
            stop     = ($urandom_range(0, 15) == 0);
            out_en   = ($urandom_range(0, 7) != 0);
            tick();
        end
        in_valid = 1'b0; stop = 1'b0; out_en = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
Parametrised, registered successor to the team's gate-level 3-to-8 decoder. It turns an N_SEL-bit select into a one-hot N_OUT-bit output and holds that output until a new command arrives. It adds a valid/ready command interface, a range check for non-power-of-two output counts, and a scan mode that walks the one-hot through the outputs with a programmable dwell time. It drives one-hot enables, such as bank selects or LED/row strobes, in the datapath.

Parameters:
N_SEL, 3, select width in bits (1..8)
N_OUT, 8, number of outputs; legal range 2..2**N_SEL; selects >= N_OUT are out of range
SCAN_DWELL, 1, cycles each output stays asserted in scan mode (>= 1)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  command valid
in_ready  output  1  command ready; a command is accepted when in_valid && in_ready
in_sel  input  N_SEL  start/decode index
in_mode  input  2  00 DECODE, 01 SCAN_ONCE, 10 SCAN_LOOP, 11 CLEAR
stop  input  1  abort an active scan
out_en  input  1  output gate
z  output  N_OUT  one-hot output; equals z_reg & {N_OUT{out_en}} (the gate is combinational)
z_valid  output  1  z_reg is non-zero (independent of out_en)
busy  output  1  scan in progress
err_range  output  1  one-cycle pulse: an accepted DECODE/SCAN command had in_sel >= N_OUT
done  output  1  one-cycle pulse: SCAN_ONCE completed

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; z_reg, dwell counter and index = 0.
  - z, z_valid, busy, err_range, done = 0. in_ready = 0 while rst_n is low.
- States: IDLE, HOLD, SCAN.
- in_ready = 1 in IDLE and HOLD, 0 in SCAN. It is combinational from state.
- Command latency: one cycle. z_reg updates on the edge that accepts the command.
- DECODE, in range:
  - z_reg = 1 << in_sel; next state HOLD.
  - In HOLD, a new DECODE replaces z_reg back-to-back with no zero gap.
- DECODE/SCAN, out of range:
  - err_range pulses for 1 cycle and z_reg clears to 0.
  - Next state IDLE, also when the command was accepted in HOLD.
- CLEAR: z_reg = 0, next state IDLE. in_sel is ignored and there is no error check.
- SCAN_ONCE / SCAN_LOOP, in range:
  - z_reg = 1 << in_sel; busy = 1; dwell counter loads SCAN_DWELL-1; state SCAN.
  - Each output is held exactly SCAN_DWELL cycles, then the index advances by 1.
  - SCAN_ONCE: after index N_OUT-1 completes its dwell, z_reg = 0, done pulses 1 cycle, busy = 0, state IDLE.
  - SCAN_LOOP: index N_OUT-1 wraps to 0, never to N_OUT..2**N_SEL-1. It runs until stopped.
- stop:
  - In SCAN: on the next edge z_reg = 0, busy = 0, state IDLE, and done is not asserted.
  - In IDLE/HOLD: stop is ignored.
  - stop and in_valid in the same SCAN cycle: stop wins; the command is not accepted because in_ready = 0.
- SCAN_ONCE started at in_sel = N_OUT-1: a single dwell, then done.
- Index arithmetic is N_SEL bits wide. Wrap is an explicit compare against N_OUT-1, not natural overflow.
- out_en = 0 does not alter state, timing or z_valid. It only masks z.
- Reset asserted mid-scan: all outputs clear immediately and asynchronously. No done pulse.
- Invariant: z_reg is always zero or exactly one-hot, with bit index < N_OUT.

Test Plan:
- N_SEL=3, N_OUT=8: DECODE each sel 0..7 back-to-back → z = 0x01,0x02,…,0x80 one cycle after each accept; z_valid = 1; no zero gap between commands.
- N_SEL=3, N_OUT=6: DECODE sel=6 while holding 0x04 → err_range = 1 for 1 cycle, z = 0x00, in_ready stays 1. Then DECODE sel=5 → z = 0x20.
- SCAN_DWELL=2, N_OUT=8, SCAN_ONCE sel=5 → z = 0x20 for 2 cycles, then 0x40 (2), 0x80 (2), then 0x00 with done for 1 cycle. busy = 1 for exactly 6 cycles; in_valid pulses during the scan are not accepted.
- N_OUT=6, SCAN_LOOP sel=4, SCAN_DWELL=1 → z = 0x10,0x20,0x01,0x02…. Assert stop together with in_valid → next cycle z = 0, busy = 0, no done, command not taken.
- DECODE sel=3 then out_en = 0 for 3 cycles → z = 0x00 and z_valid = 1 throughout. With out_en = 1 again → z = 0x08.
- SCAN_LOOP running, rst_n pulsed low mid-cycle → z, busy, z_valid = 0 immediately, before the next edge. After release: IDLE, in_ready = 1, z = 0.
